boid_frame_writer: RTL and testbench
====================================

# boid_frame_writer

Frame-rasterisation sequencer between the BPU array and the resettable boid display RAM. On each frame trigger (refresh request from CPU register or VGA screen-end) it pulses the display RAM's bank-switch/clear input once. It then scans every boid slot through the BPU read mux, converts each (x, y) to a linear pixel address, and issues one single-pixel write per on-screen boid. Off-screen boids are clipped, and triggers that arrive mid-scan are counted as overruns.

## Interface
Parameters:
- MAX_BOIDS, 64, number of boid slots scanned per frame
- BITS_FOR_BOIDS, 6, width of boid select; equals clog2(MAX_BOIDS)
- VIDEO_WIDTH, 640, pixels per line; also the y multiplier
- VIDEO_HEIGHT, 480, visible lines
- PIXEL_ADDRESS_WIDTH, 19, display RAM address width

Ports:
- Clock and reset: one clock (`clock`); reset is asynchronous and active-low (`resetn`).
- clock  in  1  system clock (50 MHz domain)
- resetn  in  1  asynchronous active-low reset
- frame_start  in  1  frame trigger level; rising edge starts a frame
- boid_sel  out  BITS_FOR_BOIDS  boid slot driven to the BPU read mux
- boid_x  in  10  x of the selected boid; combinational from the mux, same cycle as boid_sel
- boid_y  in  9  y of the selected boid; same cycle as boid_sel
- disp_switch  out  1  one-cycle pulse to the display RAM reset/bank-switch
- disp_we  out  1  display RAM write enable; write data is constant 1
- disp_addr  out  PIXEL_ADDRESS_WIDTH  display RAM write address
- busy  out  1  high from SWITCH through DRAIN
- frame_done  out  1  one-cycle pulse after the last write slot
- clip_count  out  8  boids clipped in the last completed frame
- overrun_count  out  8  triggers dropped while busy; saturating

## Operation
- Edge detect: register frame_start_q; rise = frame_start & ~frame_start_q. rise is evaluated every cycle.
- FSM states: IDLE, SWITCH, SCAN, DRAIN.
  - IDLE: on rise, go to SWITCH and clear boid counter and running clip counter.
  - SWITCH: disp_switch = 1 for this cycle only; go to SCAN.
  - SCAN: boid_sel = counter; sample boid_x/boid_y; counter increments each cycle. When counter == MAX_BOIDS-1, go to DRAIN.
  - DRAIN: the final pipelined write appears; go to IDLE. Assert frame_done next cycle; latch the running clip counter into clip_count.
- Address stage: one register stage. For each sampled pair:
  - in range = x < VIDEO_WIDTH and y < VIDEO_HEIGHT.
  - addr = x + (y<<9) + (y<<7), computed at PIXEL_ADDRESS_WIDTH bits with no overflow for in-range values.
  - Next cycle: disp_addr = addr, disp_we = in range.
  - Out of range: disp_we = 0, disp_addr holds its previous value, running clip counter +1 (saturating at 255).
- disp_we is never high outside the cycle after a SCAN cycle.
- Overrun: rise while in SWITCH, SCAN or DRAIN is ignored (no restart, scan unaffected) and overrun_count +1, saturating at 255. A rise in the IDLE cycle that carries frame_done is accepted normally.
- boid_sel holds its last value in IDLE; it is 0 after reset.

## Timing
- Reset values (asynchronous, immediate on resetn low):
  - state IDLE, frame_start_q 0
  - boid_sel 0, disp_switch 0, disp_we 0, disp_addr 0
  - busy 0, frame_done 0, clip_count 0, overrun_count 0
- Reset mid-frame: outputs clear immediately and the frame is abandoned (no frame_done, clip_count not updated). The first rise after resetn deasserts starts a fresh frame.
- Frame timeline, with rise sampled in IDLE at cycle E:
  - E+1: SWITCH, disp_switch = 1, busy = 1.
  - E+2 .. E+1+MAX_BOIDS: SCAN, boid_sel = 0 .. MAX_BOIDS-1.
  - E+3 .. E+2+MAX_BOIDS: write slot for boid k at cycle E+3+k; the last slot (E+66) is the DRAIN cycle.
  - E+3+MAX_BOIDS: IDLE, frame_done = 1, busy = 0, clip_count updated.
- Frame length is MAX_BOIDS+3 cycles trigger-to-done (67 at default). Minimum trigger period without overrun is MAX_BOIDS+3.
- frame_start held high continuously yields exactly one frame.

## Test plan
- All 64 boids at (k, 2k): one rise → disp_switch single pulse at E+1; 64 consecutive disp_we cycles E+3..E+66 with disp_addr = k + 1280k; frame_done at E+67; clip_count 0.
- Boid 5 at (639,479), boid 6 at (640,0), boid 7 at (0,480): boid 5 address 307199; no write in slots 6 and 7; clip_count = 2.
- Second rise at E+20: no restart, overrun_count = 1, write sequence identical to the single-frame case. A further 300 mid-frame rises saturate overrun_count at 255.
- Rise exactly at E+67 (the frame_done cycle) → accepted; next disp_switch at E+68, overrun_count unchanged.
- resetn low at E+30 for 2 cycles: disp_we, busy and boid_sel go to 0 immediately; no frame_done. A rise after release produces a complete 64-write frame.
- frame_start held high 500 cycles: exactly one disp_switch and one frame_done.

Source files
------------

// File: rtl/boid_frame_writer.sv
// boid_frame_writer: per-frame display RAM clear, then scan all boid slots
// and write one pixel per on-screen boid through a one-stage address pipeline.
module boid_frame_writer #(
    parameter int MAX_BOIDS           = 64,
    parameter int BITS_FOR_BOIDS      = 6,
    parameter int VIDEO_WIDTH         = 640,
    parameter int VIDEO_HEIGHT        = 480,
    parameter int PIXEL_ADDRESS_WIDTH = 19
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           frame_start,
    output logic [BITS_FOR_BOIDS-1:0]      boid_sel,
    input  logic [9:0]                     boid_x,
    input  logic [8:0]                     boid_y,
    output logic                           disp_switch,
    output logic                           disp_we,
    output logic [PIXEL_ADDRESS_WIDTH-1:0] disp_addr,
    output logic                           busy,
    output logic                           frame_done,
    output logic [7:0]                     clip_count,
    output logic [7:0]                     overrun_count
);
    typedef enum logic [1:0] {IDLE, SWITCH, SCAN, DRAIN} state_t;
    localparam logic [9:0] x_lim = 10'(VIDEO_WIDTH);
    localparam logic [9:0] y_lim = 10'(VIDEO_HEIGHT);
    localparam logic [BITS_FOR_BOIDS-1:0] last_sel = BITS_FOR_BOIDS'(MAX_BOIDS - 1);
    state_t state;
    logic frame_start_q;
    logic rise;
    logic in_range;
    logic [7:0] run_clip;
    logic [PIXEL_ADDRESS_WIDTH-1:0] addr;
    assign rise     = frame_start & ~frame_start_q;
    assign in_range = (boid_x < x_lim) && ({1'b0, boid_y} < y_lim);
    // y*640 as two shifts, so no multiplier is needed
    assign addr = PIXEL_ADDRESS_WIDTH'(boid_x) + (PIXEL_ADDRESS_WIDTH'(boid_y) << 9)
                + (PIXEL_ADDRESS_WIDTH'(boid_y) << 7);
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            frame_start_q <= 1'b0;
            boid_sel      <= '0;
            disp_switch   <= 1'b0;
            disp_we       <= 1'b0;
            disp_addr     <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            clip_count    <= '0;
            overrun_count <= '0;
            run_clip      <= '0;
        end else begin
            frame_start_q <= frame_start;
            disp_switch   <= 1'b0;
            disp_we       <= 1'b0;
            frame_done    <= 1'b0;
            if (rise && state != IDLE && overrun_count != 8'hFF)
                overrun_count <= overrun_count + 8'd1;
            case (state)
                IDLE: if (rise) begin
                    state       <= SWITCH;
                    boid_sel    <= '0;
                    run_clip    <= '0;
                    busy        <= 1'b1;
                    disp_switch <= 1'b1;
                end
                SWITCH: state <= SCAN;
                SCAN: begin
                    disp_we <= in_range;
                    if (in_range)
                        disp_addr <= addr;
                    else if (run_clip != 8'hFF)
                        run_clip <= run_clip + 8'd1;
                    if (boid_sel == last_sel)
                        state <= DRAIN;
                    else
                        boid_sel <= boid_sel + 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                    clip_count <= run_clip;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_boid_frame_writer.sv
// tb_boid_frame_writer: randomized frame scenarios checked against a
// slot-by-slot model of the expected write schedule.
module tb_boid_frame_writer;
    localparam int N = 64;
    logic        clock = 0;
    logic        resetn = 0;
    logic        frame_start = 0;
    logic [5:0]  boid_sel;
    logic [9:0]  boid_x;
    logic [8:0]  boid_y;
    logic        disp_switch, disp_we, busy, frame_done;
    logic [18:0] disp_addr;
    logic [7:0]  clip_count, overrun_count;
    logic [9:0]  bx [N];
    logic [8:0]  by [N];
    int asserts = 0;
    int fails = 0;
    int exp_ovr = 0;

    boid_frame_writer dut (
        .clock(clock), .resetn(resetn), .frame_start(frame_start),
        .boid_sel(boid_sel), .boid_x(boid_x), .boid_y(boid_y),
        .disp_switch(disp_switch), .disp_we(disp_we), .disp_addr(disp_addr),
        .busy(busy), .frame_done(frame_done), .clip_count(clip_count),
        .overrun_count(overrun_count)
    );

    assign boid_x = bx[boid_sel];
    assign boid_y = by[boid_sel];
    always #5 clock = ~clock;

    function automatic bit on_screen(int k);
        return int'(bx[k]) < 640 && int'(by[k]) < 480;
    endfunction

    // mode 0: no extra triggers, 1: one extra rise at E+20, 2: a rise every other cycle
    task automatic frame(input string tag, input int mode, input bit chain);
        int exp_clip = 0;
        bit last = 1;
        bit nxt;
        bit exp_we;
        for (int k = 0; k < N; k++) if (!on_screen(k)) exp_clip++;
        frame_start = 1;
        for (int c = 1; c <= 67; c++) begin
            @(negedge clock);
            exp_we = c >= 3 && c <= 66 && on_screen(c - 3);
            asserts++;
            if (disp_switch !== (c == 1)) begin
                fails++;
                $display("FAIL %s disp_switch c=%0d got %b expected %b", tag, c, disp_switch, c == 1);
            end
            asserts++;
            if (busy !== (c <= 66)) begin
                fails++;
                $display("FAIL %s busy c=%0d got %b expected %b", tag, c, busy, c <= 66);
            end
            asserts++;
            if (disp_we !== exp_we) begin
                fails++;
                $display("FAIL %s disp_we c=%0d got %b expected %b", tag, c, disp_we, exp_we);
            end
            if (exp_we) begin
                asserts++;
                if (int'(disp_addr) != int'(bx[c-3]) + 640 * int'(by[c-3])) begin
                    fails++;
                    $display("FAIL %s disp_addr boid %0d got %0d expected %0d", tag, c - 3,
                             disp_addr, int'(bx[c-3]) + 640 * int'(by[c-3]));
                end
            end
            asserts++;
            if (frame_done !== (c == 67)) begin
                fails++;
                $display("FAIL %s frame_done c=%0d got %b expected %b", tag, c, frame_done, c == 67);
            end
            if (c == 67) begin
                asserts++;
                if (int'(clip_count) != exp_clip) begin
                    fails++;
                    $display("FAIL %s clip_count got %0d expected %0d", tag, clip_count, exp_clip);
                end
                asserts++;
                if (int'(overrun_count) != exp_ovr) begin
                    fails++;
                    $display("FAIL %s overrun_count got %0d expected %0d", tag, overrun_count, exp_ovr);
                end
                asserts++;
                if (boid_sel !== 6'd63) begin
                    fails++;
                    $display("FAIL %s boid_sel_idle got %0d expected 63", tag, boid_sel);
                end
            end
            nxt = (c == 1) || (mode == 1 && c == 20) || (mode == 2 && c >= 4 && c <= 63 && c % 2 == 1)
                || (chain && c == 67);
            if (nxt && !last && c <= 66) exp_ovr = exp_ovr < 255 ? exp_ovr + 1 : 255;
            frame_start = nxt;
            last = nxt;
        end
        if (!chain) @(negedge clock);
    endtask

    task automatic test_reset();
        #1;
        asserts++;
        if ({boid_sel, disp_switch, disp_we, disp_addr, busy, frame_done, clip_count, overrun_count} !== '0) begin
            fails++;
            $display("FAIL reset_state got sel=%0d sw=%b we=%b addr=%0d busy=%b done=%b clip=%0d ovr=%0d expected all 0",
                     boid_sel, disp_switch, disp_we, disp_addr, busy, frame_done, clip_count, overrun_count);
        end
        @(negedge clock);
        resetn = 1;
        @(negedge clock);
    endtask

    task automatic test_diag();
        for (int k = 0; k < N; k++) begin
            bx[k] = 10'(k);
            by[k] = 9'(2 * k);
        end
        frame("diag", 0, 0);
    endtask

    task automatic test_corners();
        for (int k = 0; k < N; k++) begin
            bx[k] = 10'($urandom_range(0, 639));
            by[k] = 9'($urandom_range(0, 479));
        end
        bx[5] = 639; by[5] = 479;
        bx[6] = 640; by[6] = 0;
        bx[7] = 0;   by[7] = 480;
        frame("corners", 0, 0);
        asserts++;
        if (clip_count !== 8'd2) begin
            fails++;
            $display("FAIL corners_clip got %0d expected 2", clip_count);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N; k++) begin
                bx[k] = 10'($urandom_range(0, 720));
                by[k] = 9'($urandom_range(0, 511));
            end
            frame("random", 0, 0);
        end
    endtask

    task automatic test_overrun();
        for (int k = 0; k < N; k++) begin
            bx[k] = 10'(k);
            by[k] = 9'(2 * k);
        end
        frame("overrun_one", 1, 0);
        for (int r = 0; r < 10; r++) frame("overrun_sat", 2, 0);
        asserts++;
        if (overrun_count !== 8'd255) begin
            fails++;
            $display("FAIL overrun_saturate got %0d expected 255", overrun_count);
        end
    endtask

    task automatic test_back_to_back();
        frame("b2b_first", 0, 1);
        frame("b2b_second", 0, 0);
    endtask

    task automatic test_reset_mid_frame();
        int dones = 0;
        frame_start = 1;
        for (int c = 1; c < 30; c++) begin
            @(negedge clock);
            frame_start = (c == 1);
        end
        @(negedge clock);
        resetn = 0;
        #1;
        asserts++;
        if ({disp_we, busy, boid_sel, overrun_count} !== '0) begin
            fails++;
            $display("FAIL reset_mid got we=%b busy=%b sel=%0d ovr=%0d expected 0", disp_we, busy, boid_sel, overrun_count);
        end
        exp_ovr = 0;
        repeat (2) @(negedge clock);
        resetn = 1;
        repeat (80) begin
            @(negedge clock);
            if (frame_done) dones++;
        end
        asserts++;
        if (dones != 0) begin
            fails++;
            $display("FAIL reset_no_done got %0d expected 0", dones);
        end
        frame("post_reset", 0, 0);
    endtask

    task automatic test_held_high();
        int sw = 0;
        int dn = 0;
        frame_start = 1;
        repeat (500) begin
            @(negedge clock);
            if (disp_switch) sw++;
            if (frame_done) dn++;
        end
        frame_start = 0;
        @(negedge clock);
        asserts++;
        if (sw != 1) begin
            fails++;
            $display("FAIL held_switch got %0d expected 1", sw);
        end
        asserts++;
        if (dn != 1) begin
            fails++;
            $display("FAIL held_done got %0d expected 1", dn);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            bx[k] = '0;
            by[k] = '0;
        end
        test_reset();
        test_diag();
        test_corners();
        test_random();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_held_high();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
